fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage.sv | 67 ++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect/hazard controls and imem data in, IF/ID register and status out.
interface fetch_stage_if;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] instruction;
  logic        fimDoArquivo;
  logic [31:0] readAddress;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdInstruction;
  logic        ifIdValid;
  logic        halted;
  logic        misaligned;

  modport master (
    input  stall, branchTaken, branchTarget, instruction, fimDoArquivo,
    output readAddress, ifIdPc, ifIdInstruction, ifIdValid, halted, misaligned
  );
  modport slave (
    output stall, branchTaken, branchTarget, instruction, fimDoArquivo,
    input  readAddress, ifIdPc, ifIdInstruction, ifIdValid, halted, misaligned
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and a RUN/HALT FSM
// that stops on end-of-program or a misaligned redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic           clock,
  input logic           reset,
  fetch_stage_if.master f
);
  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ifIdPcQ;
  logic [31:0] ifIdInstrQ;
  logic        ifIdValidQ;
  logic        haltedQ;
  logic        misalignedQ;

  // PC only feeds memory; fetched data never loops back combinationally.
  assign f.readAddress     = pc;
  assign f.ifIdPc          = ifIdPcQ;
  assign f.ifIdInstruction = ifIdInstrQ;
  assign f.ifIdValid       = ifIdValidQ;
  assign f.halted          = haltedQ;
  assign f.misaligned      = misalignedQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      ifIdPcQ     <= 32'h0;
      ifIdInstrQ  <= NOP_INSTR;
      ifIdValidQ  <= 1'b0;
      haltedQ     <= 1'b0;
      misalignedQ <= 1'b0;
    end else if (f.branchTaken) begin
      // Redirect squashes the wrong-path fetch and wins over stall and HALT.
      ifIdPcQ    <= pc;
      ifIdInstrQ <= NOP_INSTR;
      ifIdValidQ <= 1'b0;
      if (f.branchTarget[1:0] == 2'b00) begin
        pc      <= f.branchTarget;
        state   <= RUN;
        haltedQ <= 1'b0;
      end else begin
        misalignedQ <= 1'b1;
        state       <= HALT;
        haltedQ     <= 1'b1;
      end
    end else if (state == HALT) begin
      ifIdValidQ <= 1'b0;
    end else if (!f.stall && (f.fimDoArquivo || f.instruction == 32'h0)) begin
      ifIdPcQ    <= pc;
      ifIdInstrQ <= NOP_INSTR;
      ifIdValidQ <= 1'b0;
      state      <= HALT;
      haltedQ    <= 1'b1;
    end else if (!f.stall) begin
      pc         <= pc + 32'd4;
      ifIdPcQ    <= pc;
      ifIdInstrQ <= f.instruction;
      ifIdValidQ <= 1'b1;
    end
  end
endmodule
